// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
//
// Instruction-driven controller for the 16-bit register-file/ALU datapath.
// Instruction words arrive over a valid/ready handshake into a small FIFO.
// Each instruction then runs as a FETCH/EXEC pair. During EXEC the decoded
// datapath control bundle is driven for exactly one cycle. A HALT parks the
// sequencer in HALTED until reset.
//
// Ports
//   CLK          clock; all state updates on the rising edge
//   RST          synchronous, active-high reset
//   INSTR        instruction word: [15:13] op, [12:10] dst, [9:7] srcA,
//                [6:4] srcB, [3:0] ignored
//   INSTR_VALID  source presents a word on INSTR
//   INSTR_READY  FIFO accepts a word this cycle (registered-full based only)
//   IE / OE      datapath input / output enable
//   WE           register-file write enable
//   S            write-back select: 00 ALU, 01 Inport, 10 ALU<<1, 11 ALU>>1
//   Opcode       ALU operation: 0 add, 1 subtract
//   ADDR_WR      register-file write address
//   ADDR_RDA/B   register-file read addresses
//   Done         HALT has executed
//   BUSY         FIFO non-empty or an instruction is executing
//   RETIRED      executed-instruction counter (wraps)
// -----------------------------------------------------------------------------
module datapath_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [15:0]      INSTR,
  input  logic             INSTR_VALID,
  output logic             INSTR_READY,
  output logic             IE,
  output logic             OE,
  output logic             WE,
  output logic [1:0]       S,
  output logic             Opcode,
  output logic [2:0]       ADDR_WR,
  output logic [2:0]       ADDR_RDA,
  output logic [2:0]       ADDR_RDB,
  output logic             Done,
  output logic             BUSY,
  output logic [CNT_W-1:0] RETIRED
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_OUT  = 3'b110,
    OP_HALT = 3'b111
  } op_e;

  // Only the meaningful 12 bits of an instruction are stored.
  typedef struct packed {
    op_e        op;
    logic [2:0] dst;
    logic [2:0] src_a;
    logic [2:0] src_b;
  } instr_t;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'b00,
    ST_EXEC   = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  state_e           state_q, state_d;
  instr_t           ir_q, ir_d;
  instr_t           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic [CNT_W-1:0] retired_q;

  logic full, empty, push, pop;

  // The low nibble of the word has no meaning for this datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^INSTR[3:0];

  // ---------------------------------------------------------------------------
  // Instruction FIFO
  // ---------------------------------------------------------------------------
  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);

  // Ready depends only on registered occupancy, so a pop in the same cycle
  // never opens a combinational path from the consumer back to the source.
  assign INSTR_READY = !full && !RST;
  assign push        = INSTR_VALID && INSTR_READY;
  assign pop         = (state_q == ST_FETCH) && !empty;

  // NOTE: FIFO storage has no reset; the occupancy count alone decides
  // which entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= instr_t'(INSTR[15:4]);
    end
  end

  // NOTE: sequential state always uses non-blocking assignment so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path through
  // the case statements can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      ST_FETCH: begin
        if (!empty) begin
          ir_d    = fifo_mem[rd_ptr_q];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC:   state_d = (ir_q.op == OP_HALT) ? ST_HALTED : ST_FETCH;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Retired counter: an instruction counts at the end of its EXEC cycle,
  // unless reset lands on that same edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      retired_q <= '0;
    end else if (state_q == ST_EXEC) begin
      retired_q <= retired_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode: controls are live only during EXEC.
  // ---------------------------------------------------------------------------
  always_comb begin
    IE       = 1'b0;
    OE       = 1'b0;
    WE       = 1'b0;
    S        = 2'b00;
    Opcode   = 1'b0;
    ADDR_WR  = 3'd0;
    ADDR_RDA = 3'd0;
    ADDR_RDB = 3'd0;
    if (state_q == ST_EXEC) begin
      unique case (ir_q.op)
        OP_LOAD: begin
          IE      = 1'b1;
          S       = 2'b01;
          WE      = 1'b1;
          ADDR_WR = ir_q.dst;
        end
        OP_ADD, OP_SUB, OP_SHL, OP_SHR: begin
          WE       = 1'b1;
          ADDR_WR  = ir_q.dst;
          ADDR_RDA = ir_q.src_a;
          ADDR_RDB = ir_q.src_b;
          Opcode   = (ir_q.op == OP_SUB);
          S        = (ir_q.op == OP_SHL) ? 2'b10 :
                     (ir_q.op == OP_SHR) ? 2'b11 : 2'b00;
        end
        OP_OUT: begin
          OE       = 1'b1;
          ADDR_RDA = ir_q.src_a;
        end
        OP_NOP, OP_HALT: ;
        default: ;
      endcase
    end
  end

  assign Done    = (state_q == ST_HALTED);
  assign BUSY    = !empty || (state_q == ST_EXEC);
  assign RETIRED = retired_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
//
// Drives datapath_sequencer with directed and random instruction streams.
// A queue-based reference model predicts every output each cycle. A small
// behavioural register file / ALU follows the DUT's control bundle, so the
// data results of LOAD/ALU/OUT sequences can be checked end to end.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [15:0]   INSTR = '0;
  logic          INSTR_VALID = 1'b0;
  logic          INSTR_READY, IE, OE, WE, Opcode, Done, BUSY;
  logic [1:0]    S;
  logic [2:0]    ADDR_WR, ADDR_RDA, ADDR_RDB;
  logic [CW-1:0] RETIRED;

  datapath_sequencer #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
    .INSTR_READY(INSTR_READY), .IE(IE), .OE(OE), .WE(WE), .S(S),
    .Opcode(Opcode), .ADDR_WR(ADDR_WR), .ADDR_RDA(ADDR_RDA),
    .ADDR_RDB(ADDR_RDB), .Done(Done), .BUSY(BUSY), .RETIRED(RETIRED)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: pending words, the instruction in EXEC (if any), halt flag.
  logic [15:0]   mq[$];
  bit            m_exec = 1'b0;
  logic [15:0]   m_ir   = '0;
  bit            m_halt = 1'b0;
  logic [CW-1:0] m_ret  = '0;

  // Behavioural datapath following the DUT controls.
  logic [15:0] regs [8];
  logic [15:0] inport   = '0;
  logic [15:0] last_out = '0;

  // Values sampled in the most recent step.
  logic          s_ready, s_busy, s_done, s_we;
  logic [CW-1:0] s_ret;

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b, 4'($urandom_range(0, 15))};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic vin, input logic [15:0] w);
    bit acc;
    if (rst) begin
      mq.delete();
      m_exec = 1'b0;
      m_halt = 1'b0;
      m_ret  = '0;
      m_ir   = '0;
    end else begin
      acc = vin && (mq.size() < DEPTH);
      if (m_exec) begin
        m_ret = m_ret + 1'b1;
        if (m_ir[15:13] == 3'd7) m_halt = 1'b1;
        m_exec = 1'b0;
      end else if (!m_halt && mq.size() > 0) begin
        m_ir   = mq.pop_front();
        m_exec = 1'b1;
      end
      if (acc) mq.push_back(w);
    end
  endtask

  // One clock cycle: compare at the falling edge, then advance DUT and model.
  task automatic step(input bit chk_en, output bit accepted);
    logic       ie_e, oe_e, we_e, opc_e, we_s;
    logic [1:0] s_e;
    logic [2:0] wr_e, ra_e, rb_e, op, wr_s;
    logic [15:0] a, b, alu, wb;
    ie_e = 0; oe_e = 0; we_e = 0; opc_e = 0; s_e = 0; wr_e = 0; ra_e = 0; rb_e = 0;
    if (m_exec) begin
      op = m_ir[15:13];
      case (op)
        3'd1: begin ie_e = 1; s_e = 2'b01; we_e = 1; wr_e = m_ir[12:10]; end
        3'd2, 3'd3, 3'd4, 3'd5: begin
          we_e = 1; wr_e = m_ir[12:10]; ra_e = m_ir[9:7]; rb_e = m_ir[6:4];
          opc_e = (op == 3'd3);
          s_e = (op == 3'd4) ? 2'b10 : (op == 3'd5) ? 2'b11 : 2'b00;
        end
        3'd6: begin oe_e = 1; ra_e = m_ir[9:7]; end
        default: ;
      endcase
    end
    @(negedge CLK);
    if (chk_en) begin
      chk("ready",   INSTR_READY, (!RST && mq.size() < DEPTH));
      chk("ie",      IE, ie_e);
      chk("oe",      OE, oe_e);
      chk("we",      WE, we_e);
      chk("s",       S, s_e);
      chk("opcode",  Opcode, opc_e);
      chk("addr_wr", ADDR_WR, wr_e);
      chk("addr_ra", ADDR_RDA, ra_e);
      chk("addr_rb", ADDR_RDB, rb_e);
      chk("done",    Done, m_halt);
      chk("busy",    BUSY, (m_exec || mq.size() > 0));
      chk("retired", RETIRED, m_ret);
    end
    s_ready = INSTR_READY; s_busy = BUSY; s_done = Done; s_we = WE; s_ret = RETIRED;
    accepted = INSTR_VALID && INSTR_READY;
    a   = regs[ADDR_RDA];
    b   = regs[ADDR_RDB];
    alu = Opcode ? a - b : a + b;
    case (S)
      2'b00:   wb = alu;
      2'b01:   wb = inport;
      2'b10:   wb = alu << 1;
      default: wb = alu >> 1;
    endcase
    if (OE === 1'b1) last_out = regs[ADDR_RDA];
    we_s = WE; wr_s = ADDR_WR;
    @(posedge CLK);
    if (we_s === 1'b1) regs[wr_s] = wb;
    model_edge(RST, INSTR_VALID, INSTR);
    #1;
  endtask

  // Hold VALID with word w until it is accepted; VALID is left high.
  task automatic push_word(input logic [15:0] w);
    bit acc;
    INSTR = w;
    INSTR_VALID = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, acc);
      if (acc) return;
    end
    chk("push_timeout", 32'd1, 32'd0);
  endtask

  task automatic run_idle(input int max_cycles);
    bit acc;
    INSTR_VALID = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!(m_exec || mq.size() > 0)) return;
      step(1'b1, acc);
    end
    chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit saw_stall;
    logic [CW-1:0] ret0;
    logic [2:0] rop;
    for (int i = 0; i < 8; i++) regs[i] = '0;

    // Reset held two cycles with VALID high: nothing may be pushed.
    RST = 1'b1; INSTR_VALID = 1'b1; INSTR = enc(3'd1, 3'd1, 3'd0, 3'd0);
    #1;
    step(1'b0, acc);
    step(1'b1, acc);
    chk("ready_in_rst", s_ready, 1'b0);
    RST = 1'b0; INSTR_VALID = 1'b0;
    step(1'b1, acc);
    chk("ready_after_rst", s_ready, 1'b1);
    chk("busy_after_rst", s_busy, 1'b0);
    chk("ret_after_rst", s_ret, 8'd0);

    // LOAD r1, LOAD r2, ADD r3=r1+r2, OUT r3.
    inport = 16'h0005; push_word(enc(3'd1, 3'd1, 3'd0, 3'd0)); run_idle(20);
    inport = 16'h0007; push_word(enc(3'd1, 3'd2, 3'd0, 3'd0)); run_idle(20);
    push_word(enc(3'd2, 3'd3, 3'd1, 3'd2)); run_idle(20);
    push_word(enc(3'd6, 3'd0, 3'd3, 3'd0)); run_idle(20);
    step(1'b1, acc);
    chk("r1_loaded", regs[1], 16'h0005);
    chk("r2_loaded", regs[2], 16'h0007);
    chk("outport_sum", last_out, 16'h000C);
    chk("retired_4", s_ret, 8'd4);

    // Back-to-back supply: occupancy builds until ready drops.
    saw_stall = 1'b0;
    ret0 = m_ret;
    for (int i = 0; i < 10; i++) begin
      INSTR = enc(3'($urandom_range(2, 5)), 3'($urandom_range(1, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      INSTR_VALID = 1'b1;
      for (int k = 0; k < 40; k++) begin
        step(1'b1, acc);
        if (!s_ready) saw_stall = 1'b1;
        if (acc) break;
      end
    end
    run_idle(40);
    chk("backpressure_seen", saw_stall, 1'b1);
    chk("backpressure_retired", m_ret - ret0, 8'd10);

    // SUB/SHL/SHR from r1=9, r2=3.
    inport = 16'h0009; push_word(enc(3'd1, 3'd1, 3'd0, 3'd0)); run_idle(20);
    inport = 16'h0003; push_word(enc(3'd1, 3'd2, 3'd0, 3'd0)); run_idle(20);
    push_word(enc(3'd3, 3'd4, 3'd1, 3'd2));
    push_word(enc(3'd4, 3'd5, 3'd1, 3'd2));
    push_word(enc(3'd5, 3'd6, 3'd1, 3'd2));
    run_idle(20);
    chk("sub_r4", regs[4], 16'h0006);
    chk("shl_r5", regs[5], 16'h0018);
    chk("shr_r6", regs[6], 16'h0006);

    // HALT then ADD: ADD must never execute.
    regs[7] = 16'hBEEF;
    push_word(enc(3'd7, 3'd0, 3'd0, 3'd0));
    push_word(enc(3'd2, 3'd7, 3'd1, 3'd2));
    INSTR_VALID = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, acc);
    chk("halt_done", s_done, 1'b1);
    chk("halt_busy", s_busy, 1'b1);
    chk("halt_no_add", regs[7], 16'hBEEF);
    RST = 1'b1; step(1'b1, acc);
    RST = 1'b0; step(1'b1, acc);
    chk("rst_clears_done", s_done, 1'b0);
    chk("rst_empties_fifo", s_busy, 1'b0);

    // Random traffic, with occasional HALT and reset.
    for (int i = 0; i < 400; i++) begin
      rop = 3'($urandom_range(0, 6));
      if ($urandom_range(0, 24) == 0) rop = 3'd7;
      INSTR = enc(rop, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
      INSTR_VALID = 1'($urandom_range(0, 1));
      RST = ($urandom_range(0, 39) == 0);
      inport = 16'($urandom);
      step(1'b1, acc);
    end
    RST = 1'b1; INSTR_VALID = 1'b0; step(1'b1, acc);
    RST = 1'b0; step(1'b1, acc);

    // Counter wrap: 256 NOPs.
    for (int i = 0; i < 256; i++) push_word(enc(3'd0, 3'd0, 3'd0, 3'd0));
    run_idle(20);
    step(1'b1, acc);
    chk("retired_wrap", s_ret, 8'd0);

    // Reset during a LOAD's EXEC: write lands, count discarded, queue flushed.
    regs[6] = '0;
    inport = 16'h1234;
    push_word(enc(3'd1, 3'd6, 3'd0, 3'd0));
    push_word(enc(3'd2, 3'd7, 3'd1, 3'd2));
    INSTR_VALID = 1'b0; RST = 1'b1;
    step(1'b1, acc);
    chk("we_at_rst", s_we, 1'b1);
    RST = 1'b0;
    step(1'b1, acc);
    chk("rst_load_written", regs[6], 16'h1234);
    chk("rst_retired_0", s_ret, 8'd0);
    chk("rst_busy_0", s_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
